// File: rtl/ldpc_wb_bridge.sv
// ldpc_wb_bridge: Wishbone slave feeding the LDPC core through an input FIFO
// and collecting its results in an output FIFO, with control/status
// registers, sticky error flags and a level interrupt.
module ldpc_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] enc_data_o,
  output logic        enc_valid_o,
  input  logic        enc_ready_i,
  input  logic [31:0] res_data_i,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  output logic        irq_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_DATA_IN  = 2'd2;
  localparam logic [1:0] REG_DATA_OUT = 2'd3;

  // Control / status state
  logic          enable_reg, irq_en_reg;
  logic          overflow_reg, underflow_reg;
  logic          ack_reg, irq_reg;
  logic [31:0]   rdata_reg, rdata_next;

  // FIFO storage and pointers
  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
  logic [AW-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
  logic [CW-1:0] in_count_reg, out_count_reg;

  // Decoded request strobes and FIFO events
  logic          req;
  logic [1:0]    reg_sel;
  logic          wr_ctrl, wr_status, wr_data, rd_out, flush;
  logic          in_full, in_empty, out_full, out_empty;
  logic          in_push_try, in_push, in_pop;
  logic          out_push, out_pop;
  logic          overflow_set, underflow_set;
  logic [31:0]   status_word;
  logic          unused_adr_bits;

  assign unused_adr_bits = ^{wbs_adr_i[7:4], wbs_adr_i[1:0]};

  // The !ack term limits a held strobe to one transfer every two cycles.
  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_reg &
                     (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_ctrl   = req & wbs_we_i & (reg_sel == REG_CTRL) & wbs_sel_i[0];
  assign wr_status = req & wbs_we_i & (reg_sel == REG_STATUS);
  assign wr_data   = req & wbs_we_i & (reg_sel == REG_DATA_IN);
  assign rd_out    = req & ~wbs_we_i & (reg_sel == REG_DATA_OUT);
  assign flush     = wr_ctrl & wbs_dat_i[2];

  assign in_full   = (in_count_reg == FULL_CNT);
  assign in_empty  = (in_count_reg == '0);
  assign out_full  = (out_count_reg == FULL_CNT);
  assign out_empty = (out_count_reg == '0);

  // A full input FIFO still accepts a word when the core pops in the same cycle.
  assign in_pop        = enc_valid_o & enc_ready_i;
  assign in_push_try   = wr_data & (wbs_sel_i == 4'hF);
  assign in_push       = in_push_try & (~in_full | in_pop);
  assign overflow_set  = in_push_try & in_full & ~in_pop;

  assign out_push      = res_valid_i & res_ready_o;
  assign out_pop       = rd_out & ~out_empty;
  assign underflow_set = rd_out & out_empty;

  assign status_word = {8'h00,
                        {(8-CW){1'b0}}, out_count_reg,
                        {(8-CW){1'b0}}, in_count_reg,
                        2'b00, underflow_reg, overflow_reg,
                        out_empty, out_full, in_empty, in_full};

  assign wbs_ack_o   = ack_reg;
  assign wbs_dat_o   = rdata_reg;
  assign irq_o       = irq_reg;
  assign enc_valid_o = enable_reg & ~in_empty;
  assign enc_data_o  = in_empty ? 32'h0 : in_mem[in_rd_ptr_reg];
  assign res_ready_o = ~out_full;

  // Select the read data captured at the request edge; writes leave it held.
  always_comb begin
    rdata_next = rdata_reg;
    if (req && !wbs_we_i) begin
      case (reg_sel)
        REG_CTRL:    rdata_next = {30'd0, irq_en_reg, enable_reg};
        REG_STATUS:  rdata_next = status_word;
        REG_DATA_IN: rdata_next = 32'h0;
        default:     rdata_next = out_empty ? 32'h0 : out_mem[out_rd_ptr_reg];
      endcase
    end
  end

  // Bus handshake, control bits, sticky flags and the registered interrupt.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg       <= 1'b0;
      rdata_reg     <= 32'h0;
      irq_reg       <= 1'b0;
      enable_reg    <= 1'b0;
      irq_en_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      ack_reg   <= req;
      rdata_reg <= rdata_next;
      irq_reg   <= irq_en_reg & ~out_empty;
      if (wr_ctrl) begin
        enable_reg <= wbs_dat_i[0];
        irq_en_reg <= wbs_dat_i[1];
      end
      if (overflow_set)
        overflow_reg <= 1'b1;
      else if (wr_status && wbs_dat_i[4])
        overflow_reg <= 1'b0;
      if (underflow_set)
        underflow_reg <= 1'b1;
      else if (wr_status && wbs_dat_i[5])
        underflow_reg <= 1'b0;
    end
  end

  // Input FIFO pointers and count; flush wins over any same-cycle push or pop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      in_wr_ptr_reg <= '0;
      in_rd_ptr_reg <= '0;
      in_count_reg  <= '0;
    end else if (flush) begin
      in_wr_ptr_reg <= '0;
      in_rd_ptr_reg <= '0;
      in_count_reg  <= '0;
    end else begin
      if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + AW'(1);
      if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + AW'(1);
      in_count_reg <= in_count_reg + CW'(in_push) - CW'(in_pop);
    end
  end

  // Output FIFO pointers and count; a result arriving with flush is discarded.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_count_reg  <= '0;
    end else if (flush) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_count_reg  <= '0;
    end else begin
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
      out_count_reg <= out_count_reg + CW'(out_push) - CW'(out_pop);
    end
  end

  // FIFO storage writes; contents need no reset because counts gate every read.
  always_ff @(posedge wb_clk_i) begin
    if (in_push && !flush)  in_mem[in_wr_ptr_reg]   <= wbs_dat_i;
    if (out_push && !flush) out_mem[out_wr_ptr_reg] <= res_data_i;
  end

endmodule

// File: tb/tb_ldpc_wb_bridge.sv
// Testbench for ldpc_wb_bridge: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_ldpc_wb_bridge;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] enc_data;
  logic        enc_valid;
  logic        enc_ready = 1'b0;
  logic [31:0] res_data = 32'h0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        irq;

  always #5 clk = ~clk;

  ldpc_wb_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .enc_data_o(enc_data), .enc_valid_o(enc_valid), .enc_ready_i(enc_ready),
    .res_data_i(res_data), .res_valid_i(res_valid), .res_ready_o(res_ready),
    .irq_o(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_en, m_irqen, m_ovf, m_unf, m_ack, m_irq;
  logic [31:0] m_dat;
  logic [31:0] q_in[$];
  logic [31:0] q_out[$];
  logic [31:0] enc_log[$];
  bit          mv_req, mv_in_pop, mv_out_pop, mv_out_push, mv_push_in, mv_flush;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0]     = (q_in.size() == DEPTH);
    s[1]     = (q_in.size() == 0);
    s[2]     = (q_out.size() == DEPTH);
    s[3]     = (q_out.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[15:8]  = 8'(q_in.size());
    s[23:16] = 8'(q_out.size());
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en = 0; m_irqen = 0; m_ovf = 0; m_unf = 0; m_ack = 0; m_irq = 0;
      m_dat = 32'h0;
      q_in.delete();
      q_out.delete();
    end else begin
      mv_req      = cyc && stb && !m_ack && (adr[31:8] == BASE[31:8]);
      mv_in_pop   = m_en && (q_in.size() > 0) && enc_ready;
      mv_out_push = res_valid && (q_out.size() < DEPTH);
      mv_out_pop  = 0;
      mv_push_in  = 0;
      mv_flush    = 0;
      m_irq       = m_irqen && (q_out.size() > 0);
      if (mv_req) begin
        case (adr[3:2])
          2'd0: begin
            if (we) begin
              if (sel[0]) begin
                m_en = wdat[0]; m_irqen = wdat[1]; mv_flush = wdat[2];
              end
            end else m_dat = {30'd0, m_irqen, m_en};
          end
          2'd1: begin
            if (we) begin
              if (wdat[4]) m_ovf = 0;
              if (wdat[5]) m_unf = 0;
            end else m_dat = m_status();
          end
          2'd2: begin
            if (we) begin
              if (sel == 4'hF) begin
                if (q_in.size() < DEPTH || mv_in_pop) mv_push_in = 1;
                else m_ovf = 1;
              end
            end else m_dat = 32'h0;
          end
          default: begin
            if (!we) begin
              if (q_out.size() > 0) begin m_dat = q_out[0]; mv_out_pop = 1; end
              else begin m_dat = 32'h0; m_unf = 1; end
            end
          end
        endcase
      end
      m_ack = mv_req;
      if (mv_in_pop) enc_log.push_back(q_in[0]);
      if (mv_flush) begin
        q_in.delete();
        q_out.delete();
      end else begin
        if (mv_in_pop)   void'(q_in.pop_front());
        if (mv_push_in)  q_in.push_back(wdat);
        if (mv_out_pop)  void'(q_out.pop_front());
        if (mv_out_push) q_out.push_back(res_data);
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    check("ack",       32'(ack),       32'(m_ack));
    check("rdata",     rdat,           m_dat);
    check("enc_valid", 32'(enc_valid), 32'(m_en && q_in.size() > 0));
    check("enc_data",  enc_data,       (q_in.size() > 0) ? q_in[0] : 32'h0);
    check("res_ready", 32'(res_ready), 32'(q_out.size() < DEPTH));
    check("irq",       32'(irq),       32'(m_irq));
  end

  // ---------------- result source / random ready ----------------
  logic [31:0] src_q[$];
  bit          src_on  = 0;
  bit          rand_en = 0;

  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = res_valid && res_ready;
      @(posedge clk);
      #1;
      if (src_on) begin
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        if (rand_en && src_q.size() == 0 && $urandom_range(0, 1) == 1)
          src_q.push_back($urandom);
        res_valid = (src_q.size() > 0) && (!rand_en || $urandom_range(0, 3) != 0);
        res_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      end
      if (rand_en) enc_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input logic [3:0] s, input bit exp_ack, output logic [31:0] rd);
    bit got;
    got = 0;
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; cyc = 1; stb = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got = 1; break; end
    end
    cyc = 0; stb = 0; we = 0;
    rd = rdat;
    check(exp_ack ? "ack_seen" : "no_ack", 32'(got), 32'(exp_ack));
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(BASE + off, 1, d, 4'hF, 1, dummy);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] d);
    wb_xfer(BASE + off, 0, 32'h0, 4'hF, 1, d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r, a, d;
    bit          w;
    logic [3:0]  s;
    int          rr;

    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;

    // Reset state
    wb_read(32'h4, r);
    check("status_after_reset", r, 32'h0000_000A);

    // Encode path
    wb_write(32'h0, 32'h1);
    wb_write(32'h8, 32'h1111_1111);
    wb_write(32'h8, 32'h2222_2222);
    @(negedge clk);
    check("enc_valid_lit", 32'(enc_valid), 32'd1);
    check("enc_data_lit", enc_data, 32'h1111_1111);
    wb_read(32'h4, r);
    check("in_count_2", 32'(r[15:8]), 32'd2);
    enc_log.delete();
    enc_ready = 1;
    repeat (2) @(negedge clk);
    enc_ready = 0;
    check("enc_log_n", 32'(enc_log.size()), 32'd2);
    if (enc_log.size() >= 2) begin
      check("enc_word0", enc_log[0], 32'h1111_1111);
      check("enc_word1", enc_log[1], 32'h2222_2222);
    end
    wb_read(32'h4, r);
    check("in_empty_after_drain", 32'(r[1]), 32'd1);

    // Overflow
    wb_write(32'h0, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) wb_write(32'h8, 32'hA0 + 32'(i));
    wb_read(32'h4, r);
    check("ovf_set", 32'(r[4]), 32'd1);
    check("ovf_count", 32'(r[15:8]), 32'(DEPTH));
    wb_write(32'h4, 32'h10);
    wb_read(32'h4, r);
    check("ovf_clr", 32'(r[4]), 32'd0);
    enc_log.delete();
    enc_ready = 1;
    wb_write(32'h0, 32'h1);
    repeat (8) @(negedge clk);
    enc_ready = 0;
    check("ovf_drain_n", 32'(enc_log.size()), 32'(DEPTH));
    for (int i = 0; i < enc_log.size(); i++) check("ovf_drain_word", enc_log[i], 32'hA0 + 32'(i));

    // Result path
    wb_write(32'h0, 32'h2);
    for (int i = 0; i < 5; i++) src_q.push_back(32'hB0 + 32'(i));
    src_on = 1;
    repeat (10) @(negedge clk);
    check("res_ready_low", 32'(res_ready), 32'd0);
    check("irq_high", 32'(irq), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wb_read(32'hC, r);
      check("data_out", r, 32'hB0 + 32'(i));
    end
    wb_read(32'hC, r);
    check("data_out_empty", r, 32'h0);
    wb_read(32'h4, r);
    check("unf_set", 32'(r[5]), 32'd1);
    check("irq_low", 32'(irq), 32'd0);
    src_on = 0;
    src_q.delete();
    res_valid = 0;
    wb_write(32'h4, 32'h20);

    // Flush race
    wb_write(32'h8, 32'hC1);
    wb_write(32'h8, 32'hC2);
    src_q.push_back(32'hD1);
    src_q.push_back(32'hD2);
    src_on = 1;
    repeat (6) @(negedge clk);
    src_on = 0;
    src_q.delete();
    res_valid = 0;
    wb_read(32'h4, r);
    check("pre_flush_counts", r & 32'h00FF_FF00, 32'h0002_0200);
    @(negedge clk);
    adr = BASE; we = 1; wdat = 32'h5; sel = 4'hF; cyc = 1; stb = 1;
    res_valid = 1; res_data = 32'hDEAD_0001;
    @(negedge clk);
    res_valid = 0; cyc = 0; stb = 0; we = 0;
    check("flush_ack", 32'(ack), 32'd1);
    wb_read(32'h4, r);
    check("post_flush_status", r, 32'h0000_000A);
    wb_read(32'h0, r);
    check("ctrl_readback", r, 32'h1);

    // Decode
    wb_xfer(BASE + 32'h100, 1, 32'h0, 4'hF, 0, r);
    wb_xfer(BASE + 32'h8, 1, 32'h5555_5555, 4'h3, 1, r);
    wb_read(32'h4, r);
    check("partial_no_push", 32'(r[15:8]), 32'd0);

    // Randomized traffic
    rand_en = 1;
    src_on  = 1;
    for (int k = 0; k < 300; k++) begin
      rr = $urandom_range(0, 3);
      a  = BASE + 32'(rr * 4);
      if ($urandom_range(0, 19) == 0) a = a + 32'h100;
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      if (rr == 0 && $urandom_range(0, 5) != 0) d[2] = 1'b0;
      wb_xfer(a, w, d, s, a[31:8] == BASE[31:8], r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_en = 0;
    src_on  = 0;
    @(negedge clk);
    src_q.delete();
    res_valid = 0;
    enc_ready = 0;

    // Mid-cycle asynchronous reset with live state
    wb_write(32'h0, 32'h3);
    wb_write(32'h8, 32'h77);
    src_q.push_back(32'h88);
    src_on = 1;
    repeat (3) @(negedge clk);
    src_on = 0;
    src_q.delete();
    res_valid = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdat, 32'h0);
    check("rst_enc_valid", 32'(enc_valid), 32'd0);
    check("rst_enc_data", enc_data, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_res_ready", 32'(res_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 0;
    wb_read(32'h4, r);
    check("status_after_midreset", r, 32'h0000_000A);
    wb_read(32'h0, r);
    check("ctrl_after_midreset", r, 32'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ldpc_wb_bridge.md
# ldpc_wb_bridge

Wishbone slave inside the user project wrapper that sits between the management SoC's Wishbone port and the LDPC encoder/decoder core. Firmware writes 32-bit message words, which are buffered in an input FIFO and streamed to the core over a valid/ready interface. Result words returned by the core are buffered in an output FIFO that firmware drains by register reads. The block also provides control, status, sticky error flags and a level interrupt.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, register window base; decode on adr[31:8].
- DEPTH, 4, entries per FIFO; power of two, 2..16.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write-enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- enc_data_o  out  32  head word of the input FIFO.
- enc_valid_o  out  1  enc_data_o is valid.
- enc_ready_i  in  1  core accepts the word.
- res_data_i  in  32  result word from the core.
- res_valid_i  in  1  result word is valid.
- res_ready_o  out  1  block can accept a result word.
- irq_o  out  1  level interrupt.

## Operation
- Request: wbs_cyc_i & wbs_stb_i & !wbs_ack_o & adr[31:8]==BASE_ADDR[31:8]. A request outside the window is never acked.
- Register map, selected by adr[3:2]:
  - 0x00 CTRL, R/W: bit0 enable, bit1 irq_en, bit2 flush (write-only, self-clearing, reads 0). Written only when sel[0]=1.
  - 0x04 STATUS:
    - Read: bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty, bit4 overflow (sticky), bit5 underflow (sticky), [15:8] input count, [23:16] output count. Other bits read 0.
    - Write: 1 to bit4 or bit5 clears that flag (write-1-to-clear). Other bits ignored.
  - 0x08 DATA_IN:
    - Write pushes wbs_dat_i into the input FIFO. Only full-word writes (sel=4'hF) push; partial writes are acked and dropped.
    - Push while full (after same-cycle pop credit): word dropped, overflow set.
    - Reads return 0.
  - 0x0C DATA_OUT:
    - Read returns the head of the output FIFO and pops it.
    - Read while empty: returns 0 and sets underflow.
    - Writes are ignored.
- Encoder side:
  - enc_valid_o = enable & !in_empty; enc_data_o = input head.
  - Pop on enc_valid_o & enc_ready_i.
  - Clearing enable holds queued words; none are lost.
- Result side:
  - res_ready_o = !out_full.
  - Push on res_valid_i & res_ready_o.
- Simultaneous push and pop on the same FIFO:
  - Both take effect; count is unchanged.
  - On a full input FIFO with a same-cycle pop, the WB push is accepted.
  - The output FIFO never accepts while full.
- Flush:
  - Empties both FIFOs at the write edge.
  - Overrides a same-cycle push or pop on either FIFO; a concurrent result word is dropped but counts as handshaken.
  - Sticky flags are unaffected.
- irq_o: registered, irq_en & !out_empty.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits, zero-extended into their 8-bit STATUS fields.

## Timing
- Reset: all outputs 0, including wbs_ack_o, wbs_dat_o, enc_valid_o and irq_o. Exception: res_ready_o=1, since the output FIFO is empty.
- Reset state: CTRL=0, both FIFOs empty, flags clear. Reset mid-transaction aborts it with no ack; FIFO contents are discarded.
- Request sampled at edge N:
  - wbs_ack_o is high for exactly the cycle after N.
  - Register and FIFO side effects occur at edge N.
  - wbs_dat_o is registered at edge N and held until the next read.
- Back-to-back requests: at most one ack every two cycles, because the request is gated by !wbs_ack_o.
- Latencies:
  - DATA_IN write at edge N: enc_valid_o high after N, provided enable=1.
  - Result handshake at edge M: out_empty=0 in STATUS from edge M; irq_o high after edge M+1.
- Full flags are derived combinationally from the registered counts. res_ready_o drops in the cycle after the filling push.

## Test plan
- Reset: assert wb_rst_i mid-cycle with no clock edge. Outputs go to reset values immediately; STATUS reads 32'h0000_000A.
- Encode path: CTRL=1, write 0x1111_1111 and 0x2222_2222 with enc_ready_i=0. enc_valid_o=1 with enc_data_o=0x1111_1111 and STATUS[15:8]=2. Raising enc_ready_i for 2 cycles delivers both words in order; in_empty=1.
- Overflow: enable=0, write DEPTH+1 words (0xA0..0xA4). STATUS bit4=1 with count=DEPTH. Writing STATUS=0x10 clears bit4. Enabling drains exactly 0xA0..0xA3.
- Result path: irq_en=1, drive 5 result words 0xB0..0xB4 continuously. res_ready_o drops after 4 words; irq_o=1. Four DATA_OUT reads return 0xB0..0xB3; the 0xB4 handshake then completes and the fifth read returns 0xB4. A sixth read returns 0, sets underflow and deasserts irq_o.
- Flush race: with 2 words in each FIFO and res_valid_i=1, write CTRL=5. Both counts are 0 next cycle and the result word is discarded; CTRL reads back 0x1.
- Decode: access BASE_ADDR+0x100 gives no ack; a sel=4'h3 write to DATA_IN is acked with no push.
